// File: rtl/dragon_stack.sv
// Parametrised stack: TOS/NOS in registers, deeper entries spilled to a
// synchronous single-port RAM, with one-cycle refill after a pop from depth.
//
// state     | meaning
// ST_IDLE   | accepting ops, o_op_ready=1
// ST_REFILL | NOS being reloaded from RAM read data, o_op_ready=0
module dragon_stack #(
  parameter int Width     = 36,
  parameter int Depth     = 512,
  parameter int DepthBits = 10
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_op_valid,
  output logic                 o_op_ready,
  input  logic [2:0]           i_op,
  input  logic [Width-1:0]     i_op_data,
  output logic [Width-1:0]     o_tos,
  output logic [Width-1:0]     o_nos,
  output logic [DepthBits-1:0] o_count,
  output logic                 o_overflow,
  output logic                 o_underflow,
  input  logic                 i_error_clear
);

  localparam int MemWords = Depth - 2;
  localparam int AddrBits = $clog2(MemWords);

  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_BINARY  = 3'd3;
  localparam logic [2:0] OP_REPLACE = 3'd4;
  localparam logic [2:0] OP_DUP     = 3'd5;
  localparam logic [2:0] OP_SWAP    = 3'd6;

  localparam logic [DepthBits-1:0] C0     = '0;
  localparam logic [DepthBits-1:0] C1     = DepthBits'(1);
  localparam logic [DepthBits-1:0] C2     = DepthBits'(2);
  localparam logic [DepthBits-1:0] CDepth = DepthBits'(Depth);

  typedef enum logic {ST_IDLE, ST_REFILL} state_t;

  state_t               r_state;
  logic                 r_ready;
  logic [Width-1:0]     r_tos;
  logic [Width-1:0]     r_nos;
  logic [DepthBits-1:0] r_count;
  logic                 r_overflow;
  logic                 r_underflow;
  logic [Width-1:0]     r_mem [0:MemWords-1];
  logic [Width-1:0]     r_rd_data;

  logic                 w_accept;
  logic                 w_ok;
  logic                 w_ovf_err;
  logic                 w_unf_err;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_do;
  logic [DepthBits-1:0] w_mem_count;
  logic [AddrBits-1:0]  w_wr_addr;
  logic [AddrBits-1:0]  w_rd_addr;

  assign w_accept    = i_op_valid && r_ready;
  assign w_mem_count = (r_count >= C2) ? (r_count - C2) : C0;
  assign w_wr_addr   = AddrBits'(w_mem_count);
  assign w_rd_addr   = AddrBits'(w_mem_count - C1);

  // Only PUSH reports overflow; every other rejected op, DUP on a full stack included, is an underflow.
  always_comb begin
    w_ok      = 1'b1;
    w_ovf_err = 1'b0;
    w_unf_err = 1'b0;
    w_wr      = 1'b0;
    w_rd      = 1'b0;
    case (i_op)
      OP_PUSH: begin
        if (r_count == CDepth) begin
          w_ok      = 1'b0;
          w_ovf_err = w_accept;
        end else begin
          w_wr = (r_count >= C2);
        end
      end
      OP_DUP: begin
        if (r_count == C0 || r_count == CDepth) begin
          w_ok      = 1'b0;
          w_unf_err = w_accept;
        end else begin
          w_wr = (r_count >= C2);
        end
      end
      OP_POP, OP_REPLACE: begin
        if (r_count == C0) begin
          w_ok      = 1'b0;
          w_unf_err = w_accept;
        end else begin
          w_rd = (i_op == OP_POP) && (r_count > C2);
        end
      end
      OP_BINARY, OP_SWAP: begin
        if (r_count < C2) begin
          w_ok      = 1'b0;
          w_unf_err = w_accept;
        end else begin
          w_rd = (i_op == OP_BINARY) && (r_count > C2);
        end
      end
      default: ;
    endcase
  end

  assign w_do = w_accept && w_ok;

  always_ff @(posedge i_clock) begin
    if (w_do && w_wr) r_mem[w_wr_addr] <= r_nos;
    if (w_do && w_rd) r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_tos       <= '0;
      r_nos       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  && !i_error_clear) || w_ovf_err;
      r_underflow <= (r_underflow && !i_error_clear) || w_unf_err;
      case (r_state)
        ST_IDLE: begin
          if (w_do) begin
            case (i_op)
              OP_PUSH: begin
                r_nos   <= r_tos;
                r_tos   <= i_op_data;
                r_count <= r_count + C1;
              end
              OP_DUP: begin
                r_nos   <= r_tos;
                r_count <= r_count + C1;
              end
              OP_POP, OP_BINARY: begin
                r_tos   <= (i_op == OP_POP) ? r_nos : i_op_data;
                r_count <= r_count - C1;
                if (w_rd) begin
                  r_state <= ST_REFILL;
                  r_ready <= 1'b0;
                end else begin
                  r_nos <= '0;
                end
              end
              OP_REPLACE: r_tos <= i_op_data;
              OP_SWAP: begin
                r_tos <= r_nos;
                r_nos <= r_tos;
              end
              default: ;
            endcase
          end
        end
        ST_REFILL: begin
          r_nos   <= r_rd_data;
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_op_ready  = r_ready;
  assign o_tos       = r_tos;
  assign o_nos       = r_nos;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_dragon_stack.sv
// Bench for dragon_stack: queue-based stack model checked every cycle, plus
// directed scenarios with literal expectations and a randomized run.
module tb_dragon_stack;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int DB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          clr;
  logic [2:0]    op;
  logic [W-1:0]  data;
  logic          ready;
  logic [W-1:0]  tos;
  logic [W-1:0]  nos;
  logic [DB-1:0] count;
  logic          ovf;
  logic          unf;

  dragon_stack #(.Width(W), .Depth(D), .DepthBits(DB)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_op_valid   (valid),
    .o_op_ready   (ready),
    .i_op         (op),
    .i_op_data    (data),
    .o_tos        (tos),
    .o_nos        (nos),
    .o_count      (count),
    .o_overflow   (ovf),
    .o_underflow  (unf),
    .i_error_clear(clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_stk[0] is the top of stack.
  logic [W-1:0] m_stk[$];
  bit m_ovf, m_unf, m_busy;
  bit chk_en = 1'b0;

  task automatic expect_eq(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_tos();
    return (m_stk.size() >= 1) ? int'(m_stk[0]) : 0;
  endfunction

  function automatic int m_nos();
    return (m_stk.size() >= 2) ? int'(m_stk[1]) : 0;
  endfunction

  task automatic model_reset();
    m_stk.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic model_step();
    bit e_o, e_u;
    int n;
    logic [W-1:0] t;
    e_o = 1'b0;
    e_u = 1'b0;
    n   = m_stk.size();
    if (m_busy) begin
      m_busy = 1'b0;
    end else if (valid) begin
      case (op)
        3'd1: if (n == D) e_o = 1'b1; else m_stk.push_front(data);
        3'd2: if (n < 1) e_u = 1'b1;
              else begin void'(m_stk.pop_front()); m_busy = (n > 2); end
        3'd3: if (n < 2) e_u = 1'b1;
              else begin
                void'(m_stk.pop_front());
                void'(m_stk.pop_front());
                m_stk.push_front(data);
                m_busy = (n > 2);
              end
        3'd4: if (n < 1) e_u = 1'b1; else m_stk[0] = data;
        3'd5: if (n < 1 || n == D) e_u = 1'b1;
              else begin t = m_stk[0]; m_stk.push_front(t); end
        3'd6: if (n < 2) e_u = 1'b1;
              else begin t = m_stk[0]; m_stk[0] = m_stk[1]; m_stk[1] = t; end
        default: ;
      endcase
    end
    m_ovf = (m_ovf && !clr) || e_o;
    m_unf = (m_unf && !clr) || e_u;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      expect_eq("ready", int'(ready), int'(!m_busy));
      expect_eq("count", int'(count), m_stk.size());
      expect_eq("tos", int'(tos), m_tos());
      expect_eq("overflow", int'(ovf), int'(m_ovf));
      expect_eq("underflow", int'(unf), int'(m_unf));
      if (!m_busy) expect_eq("nos", int'(nos), m_nos());
    end
  end

  task automatic op_cycle(input bit v, input logic [2:0] o, input logic [W-1:0] d, input bit c);
    valid = v;
    op    = o;
    data  = d;
    clr   = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    valid = 1'b0;
    clr   = 1'b0;
  endtask

  // Checks the DUT and the model against a hand-computed value.
  task automatic lit(input string name, input int dut_val, input int mdl_val, input int exp);
    expect_eq({name, "_dut"}, dut_val, exp);
    expect_eq({name, "_model"}, mdl_val, exp);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    valid = 1'b0; op = 3'd0; data = '0; clr = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    rst    = 1'b0;
    chk_en = 1'b1;
    #1;
    lit("rst_count", int'(count), m_stk.size(), 0);
    lit("rst_tos", int'(tos), m_tos(), 0);
    lit("rst_nos", int'(nos), m_nos(), 0);
    lit("rst_ready", int'(ready), int'(!m_busy), 1);
    lit("rst_flags", int'({ovf, unf}), int'({m_ovf, m_unf}), 0);

    // Push three, pop with refill from RAM[0]
    op_cycle(1, 3'd1, 8'h11, 0); lit("p1_ready", int'(ready), int'(!m_busy), 1);
    op_cycle(1, 3'd1, 8'h22, 0); lit("p2_ready", int'(ready), int'(!m_busy), 1);
    op_cycle(1, 3'd1, 8'h33, 0); lit("p3_ready", int'(ready), int'(!m_busy), 1);
    lit("p3_count", int'(count), m_stk.size(), 3);
    lit("p3_tos", int'(tos), m_tos(), 'h33);
    lit("p3_nos", int'(nos), m_nos(), 'h22);
    op_cycle(1, 3'd2, 8'h00, 0);
    lit("pop_tos", int'(tos), m_tos(), 'h22);
    lit("pop_count", int'(count), m_stk.size(), 2);
    lit("pop_ready", int'(ready), int'(!m_busy), 0);
    op_cycle(0, 3'd0, 8'h00, 0);
    lit("refill_nos", int'(nos), m_nos(), 'h11);
    lit("refill_ready", int'(ready), int'(!m_busy), 1);

    // BINARY with refill
    hard_reset();
    op_cycle(1, 3'd1, 8'h03, 0);
    op_cycle(1, 3'd1, 8'h07, 0);
    op_cycle(1, 3'd1, 8'h05, 0);
    op_cycle(1, 3'd3, 8'h0C, 0);
    lit("bin_tos", int'(tos), m_tos(), 12);
    lit("bin_count", int'(count), m_stk.size(), 2);
    lit("bin_ready", int'(ready), int'(!m_busy), 0);
    op_cycle(0, 3'd0, 8'h00, 0);
    lit("bin_nos", int'(nos), m_nos(), 3);

    // Overflow at full, clear, clear colliding with a new error, drain
    hard_reset();
    for (int i = 1; i <= 4; i++) op_cycle(1, 3'd1, 8'(i), 0);
    op_cycle(1, 3'd1, 8'h09, 0);
    lit("ovf_flag", int'(ovf), int'(m_ovf), 1);
    lit("ovf_tos", int'(tos), m_tos(), 4);
    lit("ovf_count", int'(count), m_stk.size(), 4);
    op_cycle(0, 3'd0, 8'h00, 1);
    lit("ovf_clear", int'(ovf), int'(m_ovf), 0);
    op_cycle(1, 3'd1, 8'h09, 1);
    lit("ovf_clr_collide", int'(ovf), int'(m_ovf), 1);
    for (int i = 0; i < 3; i++) begin
      op_cycle(1, 3'd2, 8'h00, 0);
      op_cycle(0, 3'd0, 8'h00, 0);
    end
    lit("drain_tos", int'(tos), m_tos(), 1);

    // Underflow on SWAP at Count=1 and POP at Count=0
    hard_reset();
    op_cycle(1, 3'd1, 8'h05, 0);
    op_cycle(1, 3'd6, 8'h00, 0);
    lit("swap_unf", int'(unf), int'(m_unf), 1);
    lit("swap_tos", int'(tos), m_tos(), 5);
    lit("swap_count", int'(count), m_stk.size(), 1);
    op_cycle(1, 3'd2, 8'h00, 0);
    lit("pop1_count", int'(count), m_stk.size(), 0);
    op_cycle(1, 3'd2, 8'h00, 0);
    lit("pop0_unf", int'(unf), int'(m_unf), 1);
    lit("pop0_count", int'(count), m_stk.size(), 0);

    // Reset during REFILL
    hard_reset();
    op_cycle(1, 3'd6, 8'h00, 0);
    op_cycle(1, 3'd1, 8'h0A, 0);
    op_cycle(1, 3'd1, 8'h0B, 0);
    op_cycle(1, 3'd1, 8'h0C, 0);
    op_cycle(1, 3'd2, 8'h00, 0);
    lit("pre_rst_ready", int'(ready), int'(!m_busy), 0);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    lit("mid_rst_count", int'(count), m_stk.size(), 0);
    lit("mid_rst_tos", int'(tos), m_tos(), 0);
    lit("mid_rst_nos", int'(nos), m_nos(), 0);
    lit("mid_rst_ready", int'(ready), int'(!m_busy), 1);
    lit("mid_rst_flags", int'({ovf, unf}), int'({m_ovf, m_unf}), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [2:0] o;
      r = int'($urandom_range(0, 9));
      if (r < 4)      o = 3'd1;
      else if (r < 6) o = 3'd2;
      else            o = 3'($urandom_range(0, 7));
      op_cycle(($urandom_range(0, 3) != 0), o, 8'($urandom), ($urandom_range(0, 15) == 0));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
